axis_decim_avg: RTL and testbench

//  AXI-Stream decimating boxcar accumulator: sums DECIM consecutive signed input samples,

---
 rtl/axis_decim_avg.sv | 107 ++++++++++
 tb/tb_axis_decim_avg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_decim_avg.sv
// rtl/axis_decim_avg.sv - decimating boxcar accumulator on an AXI-Stream sample path
// Sums DECIM signed beats, then rounds half-up, shifts and saturates to one DW-bit output beat.
module axis_decim_avg #(
  parameter int DW    = 24,
  parameter int DECIM = 4,
  parameter int SHIFT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          sat,
  input  logic          sat_clr
);

  localparam int LD       = $clog2(DECIM);
  localparam int CW       = (LD > 0) ? LD : 1;
  localparam int AW       = DW + LD + 1;
  localparam int SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [CW-1:0]        CNT_LAST = CW'(DECIM - 1);
  localparam logic signed [AW-1:0] BIAS     = (SHIFT > 0) ? AW'(1 << SHIFT_M1) : '0;
  localparam logic signed [AW-1:0] MAXV     = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV     = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sample_ext;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] biased;
  logic signed [AW-1:0] rnd;
  logic [CW-1:0]        cnt;
  logic [DW-1:0]        out_next;
  logic                 clip;
  logic                 last_beat;
  logic                 accept;
  logic                 close;
  logic                 out_take;

  assign last_beat = (cnt == CNT_LAST);

  // Only the group-closing beat needs the output register, so only it waits on downstream.
  assign s_axis_tready = !last_beat || !m_axis_tvalid || m_axis_tready;

  assign accept   = s_axis_tvalid && s_axis_tready;
  assign close    = accept && last_beat;
  assign out_take = m_axis_tvalid && m_axis_tready;

  assign sample_ext = {{(AW-DW){s_axis_tdata[DW-1]}}, s_axis_tdata};
  assign sum        = acc + sample_ext;
  assign biased     = sum + BIAS;
  assign rnd        = biased >>> SHIFT;

  always_comb begin
    out_next = rnd[DW-1:0];
    clip     = 1'b0;
    if (rnd > MAXV) begin
      out_next = MAXV[DW-1:0];
      clip     = 1'b1;
    end else if (rnd < MINV) begin
      out_next = MINV[DW-1:0];
      clip     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (last_beat) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CW'(1);
      end
    end
  end

  // A closing group reloads the output even while the previous sample is being taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (close) begin
      m_axis_tdata  <= out_next;
      m_axis_tvalid <= 1'b1;
    end else if (out_take) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat <= 1'b0;
    end else if (close && clip) begin
      sat <= 1'b1;
    end else if (sat_clr) begin
      sat <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_decim_avg.sv
// tb/tb_axis_decim_avg.sv - directed vectors and random handshake run for axis_decim_avg
// DUT a/b share DECIM=4 stimulus (SHIFT 2 and 0); DUT c is DECIM=8, SHIFT=3.
module tb_axis_decim_avg;
  localparam int DW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b1;
  logic          sat_clr = 1'b0;
  logic          sr_a, sr_b, mv_a, mv_b, sat_a, sat_b;
  logic [DW-1:0] md_a, md_b;

  logic [DW-1:0] c_data = '0;
  logic          c_valid = 1'b0;
  logic          c_mready = 1'b1;
  logic          c_satclr = 1'b0;
  logic          c_sready, c_mvalid, c_sat;
  logic [DW-1:0] c_mdata;

  axis_decim_avg #(.DW(DW), .DECIM(4), .SHIFT(2)) u_a (
    .clk(clk), .rst(rst), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(sr_a),
    .m_axis_tdata(md_a), .m_axis_tvalid(mv_a), .m_axis_tready(m_ready), .sat(sat_a), .sat_clr(sat_clr));
  axis_decim_avg #(.DW(DW), .DECIM(4), .SHIFT(0)) u_b (
    .clk(clk), .rst(rst), .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(sr_b),
    .m_axis_tdata(md_b), .m_axis_tvalid(mv_b), .m_axis_tready(m_ready), .sat(sat_b), .sat_clr(sat_clr));
  axis_decim_avg #(.DW(DW), .DECIM(8), .SHIFT(3)) u_c (
    .clk(clk), .rst(rst), .s_axis_tdata(c_data), .s_axis_tvalid(c_valid), .s_axis_tready(c_sready),
    .m_axis_tdata(c_mdata), .m_axis_tvalid(c_mvalid), .m_axis_tready(c_mready), .sat(c_sat), .sat_clr(c_satclr));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] v);
    int n;
    s_valid = 1'b1;
    s_data  = v;
    #1;
    n = 0;
    while (!sr_a && n < 50) begin
      tick();
      n++;
    end
    chk("beat_ready", {31'd0, sr_a}, 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_group(input logic [3:0][DW-1:0] d);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("pre_close_valid", {31'd0, mv_a}, 32'd0);
      send_beat(d[i]);
    end
  endtask

  typedef struct packed {
    logic [3:0][DW-1:0] d;
    logic [DW-1:0]      ea;
    logic [DW-1:0]      eb;
    logic               sb;
  } vec_t;

  vec_t vecs[8];

  task automatic run_random();
    longint acc_m = 0;
    longint q[$];
    longint e;
    int cnt_m = 0;
    int beats = 0;
    int outs = 0;
    int cyc = 0;
    while ((beats < 1000 || q.size() > 0 || c_mvalid) && cyc < 20000) begin
      tick();
      c_valid  = (beats < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      c_data   = DW'($urandom);
      c_mready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (c_mvalid && c_mready) begin
        if (q.size() == 0) begin
          chk("rand_extra_output", {31'd0, c_mvalid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rand_out", {8'd0, c_mdata}, {8'd0, e[DW-1:0]});
          outs++;
        end
      end
      if (c_valid && c_sready) begin
        acc_m += longint'($signed(c_data));
        cnt_m++;
        beats++;
        if (cnt_m == 8) begin
          q.push_back((acc_m + 4) >>> 3);
          acc_m = 0;
          cnt_m = 0;
        end
      end
      cyc++;
    end
    c_valid = 1'b0;
    chk("rand_beats", beats, 32'd1000);
    chk("rand_outputs", outs, 32'd125);
    chk("rand_pending", q.size(), 32'd0);
    chk("rand_sat", {31'd0, c_sat}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{d: {24'd4, 24'd3, 24'd2, 24'd1}, ea: 24'd3, eb: 24'd10, sb: 1'b0};
    vecs[1] = '{d: {24'hFFFFFC, 24'hFFFFFD, 24'hFFFFFE, 24'hFFFFFF}, ea: 24'hFFFFFE, eb: 24'hFFFFF6, sb: 1'b0};
    vecs[2] = '{d: {4{24'h7FFFFF}}, ea: 24'h7FFFFF, eb: 24'h7FFFFF, sb: 1'b1};
    vecs[3] = '{d: {4{24'h800000}}, ea: 24'h800000, eb: 24'h800000, sb: 1'b1};
    vecs[4] = '{d: {24'd1, 24'd0, 24'd0, 24'd1}, ea: 24'd1, eb: 24'd2, sb: 1'b1};
    vecs[5] = '{d: {24'd0, 24'd0, 24'hFFFFFF, 24'hFFFFFF}, ea: 24'd0, eb: 24'hFFFFFE, sb: 1'b1};
    vecs[6] = '{d: {24'd1, 24'd0, 24'd0, 24'd0}, ea: 24'd0, eb: 24'd1, sb: 1'b1};
    vecs[7] = '{d: {24'd0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}, ea: 24'hFFFFFF, eb: 24'hFFFFFD, sb: 1'b1};

    tick();
    tick();
    chk("rst_valid", {31'd0, mv_a}, 32'd0);
    chk("rst_data", {8'd0, md_a}, 32'd0);
    chk("rst_sat", {30'd0, sat_a, sat_b}, 32'd0);
    chk("rst_ready", {31'd0, sr_a}, 32'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      send_group(vecs[i].d);
      chk($sformatf("v%0d_valid", i), {30'd0, mv_a, mv_b}, 32'd3);
      chk($sformatf("v%0d_data_a", i), {8'd0, md_a}, {8'd0, vecs[i].ea});
      chk($sformatf("v%0d_data_b", i), {8'd0, md_b}, {8'd0, vecs[i].eb});
      chk($sformatf("v%0d_sat", i), {30'd0, sat_a, sat_b}, {31'd0, vecs[i].sb});
      tick();
      chk($sformatf("v%0d_drained", i), {31'd0, mv_a}, 32'd0);
    end

    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_clr", {30'd0, sat_a, sat_b}, 32'd0);
    sat_clr = 1'b1;
    send_group({4{24'h7FFFFF}});
    sat_clr = 1'b0;
    chk("sat_set_wins", {31'd0, sat_b}, 32'd1);
    tick();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;

    send_group({24'd4, 24'd3, 24'd2, 24'd1});
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(24'd5);
    s_valid = 1'b1;
    s_data  = 24'd5;
    #1;
    chk("bp_stall_ready", {31'd0, sr_a}, 32'd0);
    tick();
    chk("bp_hold_data", {8'd0, md_a}, 32'd3);
    chk("bp_hold_valid", {30'd0, mv_a, sr_a}, 32'd2);
    m_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, sr_a}, 32'd1);
    tick();
    s_valid = 1'b0;
    chk("bp_next_valid", {31'd0, mv_a}, 32'd1);
    chk("bp_next_data_a", {8'd0, md_a}, 32'd5);
    chk("bp_next_data_b", {8'd0, md_b}, 32'd20);
    tick();
    chk("bp_drained", {31'd0, mv_a}, 32'd0);

    send_beat(24'd5);
    send_beat(24'd5);
    rst = 1'b1;
    tick();
    chk("rst_mid_outputs", {7'd0, md_a, mv_a}, 32'd0);
    rst = 1'b0;
    send_group({24'd4, 24'd3, 24'd2, 24'd1});
    chk("rst_mid_data_a", {7'd0, md_a, mv_a}, {7'd0, 24'd3, 1'b1});
    chk("rst_mid_data_b", {8'd0, md_b}, 32'd10);

    m_ready = 1'b0;
    tick();
    chk("pend_valid", {31'd0, mv_a}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    chk("pend_dropped", {7'd0, md_a, mv_a}, 32'd0);
    tick();

    run_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
